// File: rtl/regfile_wb_ctrl_if.sv
// Write-back request/grant bundle shared by the two requesters (A: ALU/branch, B: load unit).
// The master side drives requests, the controller (slave) returns combinational grants.
interface regfile_wb_ctrl_if #(
    parameter int AW    = 5,
    parameter int WIDTH = 32
);
    logic             req_a;
    logic [AW-1:0]    addr_a;
    logic [WIDTH-1:0] data_a;
    logic             gnt_a;
    logic             req_b;
    logic [AW-1:0]    addr_b;
    logic [WIDTH-1:0] data_b;
    logic             gnt_b;

    modport master (
        output req_a, addr_a, data_a,
        output req_b, addr_b, data_b,
        input  gnt_a, gnt_b
    );

    modport slave (
        input  req_a, addr_a, data_a,
        input  req_b, addr_b, data_b,
        output gnt_a, gnt_b
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: round-robin write-port sharing, registered write
// port and busy scoreboard for issue hazards. Define REGFILE_FWD_EN to forward in-flight data.
module regfile_wb_ctrl #(
    parameter  int N     = 32,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_wb_ctrl_if.slave wb,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic [AW-1:0]    iss_rs1,
    input  logic [AW-1:0]    iss_rs2,
    output logic             iss_stall,
    output logic             rf_we,
    output logic [AW-1:0]    rf_a3,
    output logic [WIDTH-1:0] rf_wd3,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [WIDTH-1:0] fwd_data
);

    typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_t;

    rr_t              rr_reg;
    rr_t              rr_next;
    logic             rf_we_reg;
    logic [AW-1:0]    rf_a3_reg;
    logic [WIDTH-1:0] rf_wd3_reg;
    logic [N-1:0]     busy_reg;
    logic [N-1:0]     busy_next;

    logic             wb_fire;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             iss_fire;
    logic             raw_inf1;
    logic             raw_inf2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_reg     <= RR_A;
            rf_we_reg  <= 1'b0;
            rf_a3_reg  <= '0;
            rf_wd3_reg <= '0;
            busy_reg   <= '0;
        end else begin
            rr_reg    <= rr_next;
            rf_we_reg <= wb_fire && (wb_addr != '0);
            if (wb_fire) begin
                rf_a3_reg  <= wb_addr;
                rf_wd3_reg <= wb_data;
            end
            busy_reg <= busy_next;
        end
    end

    // The pointer only moves on contention so a lone requester never loses its turn.
    always_comb begin
        rr_next  = rr_reg;
        wb.gnt_a = 1'b0;
        wb.gnt_b = 1'b0;
        if (wb.req_a && wb.req_b) begin
            if (rr_reg == RR_A) begin
                wb.gnt_a = 1'b1;
                rr_next  = RR_B;
            end else begin
                wb.gnt_b = 1'b1;
                rr_next  = RR_A;
            end
        end else begin
            wb.gnt_a = wb.req_a;
            wb.gnt_b = wb.req_b;
        end
    end

    assign wb_fire = wb.gnt_a || wb.gnt_b;
    assign wb_addr = wb.gnt_b ? wb.addr_b : wb.addr_a;
    assign wb_data = wb.gnt_b ? wb.data_b : wb.data_a;

    assign iss_fire = iss_valid && !iss_stall;

    // Issue set has priority over write-back clear: the newer producer is still outstanding.
    assign busy_next[0] = 1'b0;
    for (genvar gi = 1; gi < N; gi++) begin : g_busy
        assign busy_next[gi] = (iss_fire && (iss_rd == AW'(gi))) ? 1'b1 :
                               (wb_fire && (wb_addr == AW'(gi))) ? 1'b0 :
                               busy_reg[gi];
    end

`ifdef REGFILE_FWD_EN
    assign raw_inf1 = 1'b0;
    assign raw_inf2 = 1'b0;
    assign fwd_hit1 = rf_we_reg && (rf_a3_reg == iss_rs1) && (iss_rs1 != '0);
    assign fwd_hit2 = rf_we_reg && (rf_a3_reg == iss_rs2) && (iss_rs2 != '0);
    assign fwd_data = rf_wd3_reg;
`else
    // A write sitting in the output register is not yet readable from the register file.
    assign raw_inf1 = rf_we_reg && (rf_a3_reg == iss_rs1);
    assign raw_inf2 = rf_we_reg && (rf_a3_reg == iss_rs2);
    assign fwd_hit1 = 1'b0;
    assign fwd_hit2 = 1'b0;
    assign fwd_data = '0;
`endif

    assign iss_stall = ((iss_rs1 != '0) && (busy_reg[iss_rs1] || raw_inf1)) ||
                       ((iss_rs2 != '0) && (busy_reg[iss_rs2] || raw_inf2)) ||
                       ((iss_rd  != '0) &&  busy_reg[iss_rd]);

    assign rf_we  = rf_we_reg;
    assign rf_a3  = rf_a3_reg;
    assign rf_wd3 = rf_wd3_reg;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: grants come from a round-robin reference model,
// expected register-file writes are queued when driven and popped one cycle later.
module tb_regfile_wb_ctrl;

    localparam int N     = 32;
    localparam int WIDTH = 32;
    localparam int AW    = $clog2(N);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             iss_valid;
    logic [AW-1:0]    iss_rd, iss_rs1, iss_rs2;
    logic             iss_stall;
    logic             rf_we;
    logic [AW-1:0]    rf_a3;
    logic [WIDTH-1:0] rf_wd3;
    logic             fwd_hit1, fwd_hit2;
    logic [WIDTH-1:0] fwd_data;

    regfile_wb_ctrl_if #(.AW(AW), .WIDTH(WIDTH)) wb();

    regfile_wb_ctrl #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wb),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_stall (iss_stall),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             we;
        logic [AW-1:0]    a3;
        logic [WIDTH-1:0] wd3;
    } wb_exp_t;

    typedef struct packed {
        logic             ra;
        logic [AW-1:0]    aa;
        logic [WIDTH-1:0] da;
        logic             rb;
        logic [AW-1:0]    ab;
        logic [WIDTH-1:0] db;
    } req_t;

    wb_exp_t          exp_q[$];
    int               pass_cnt = 0;
    int               total_cnt = 0;
    logic             m_rr;
    logic [AW-1:0]    m_a3;
    logic [WIDTH-1:0] m_wd3;

    task automatic set_reqs(input req_t r);
        wb.req_a  = r.ra;
        wb.addr_a = r.aa;
        wb.data_a = r.da;
        wb.req_b  = r.rb;
        wb.addr_b = r.ab;
        wb.data_b = r.db;
    endtask

    task automatic set_issue(input logic v, input logic [AW-1:0] rd,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        iss_valid = v;
        iss_rd    = rd;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
    endtask

    // Reference arbiter: grants for the present requests, queues the register-file
    // outputs expected after the coming edge, and advances the round-robin pointer.
    task automatic model_step(output logic ga, output logic gb);
        wb_exp_t e;
        ga = wb.req_a && (!wb.req_b || (m_rr == 1'b0));
        gb = wb.req_b && (!wb.req_a || (m_rr == 1'b1));
        if (ga) begin
            m_a3  = wb.addr_a;
            m_wd3 = wb.data_a;
        end else if (gb) begin
            m_a3  = wb.addr_b;
            m_wd3 = wb.data_b;
        end
        e.we  = (ga || gb) && (m_a3 != '0);
        e.a3  = m_a3;
        e.wd3 = m_wd3;
        exp_q.push_back(e);
        if (wb.req_a && wb.req_b) m_rr = ga ? 1'b1 : 1'b0;
    endtask

    task automatic test_reset();
        req_t    r;
        wb_exp_t e;
        logic    ga, gb;
        r = '{ra: 1'b1, aa: AW'(3), da: 32'h0000_0033, rb: 1'b0, ab: '0, db: '0};
        rst_n = 1'b0;
        set_issue(1'b0, '0, '0, '0);
        set_reqs(r);
        repeat (2) @(negedge clk);
        #1;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (rf_a3 !== '0) $display("FAIL reset_rf_a3: got %0d want 0", rf_a3); else pass_cnt++;
        total_cnt++; if (rf_wd3 !== '0) $display("FAIL reset_rf_wd3: got %h want 0", rf_wd3); else pass_cnt++;
        total_cnt++; if (wb.gnt_a !== 1'b1) $display("FAIL reset_gnt_a: got %0b want 1", wb.gnt_a); else pass_cnt++;
        total_cnt++; if (dut.busy_reg !== '0) $display("FAIL reset_busy: got %h want 0", dut.busy_reg); else pass_cnt++;
        rst_n = 1'b1;
        m_rr  = 1'b0;
        m_a3  = '0;
        m_wd3 = '0;
        exp_q.delete();
        model_step(ga, gb);
        total_cnt++; if (wb.gnt_a !== ga) $display("FAIL reset_first_gnt_a: got %0b want %0b", wb.gnt_a, ga); else pass_cnt++;
        $display("txn reset_release gnt_a=%0b gnt_b=%0b addr=%0d", wb.gnt_a, wb.gnt_b, r.aa);
        @(negedge clk);
        e = exp_q.pop_front();
        total_cnt++; if (rf_we !== e.we || rf_a3 !== e.a3 || rf_wd3 !== e.wd3)
            $display("FAIL reset_first_write: got we=%0b a3=%0d wd3=%h want we=%0b a3=%0d wd3=%h",
                     rf_we, rf_a3, rf_wd3, e.we, e.a3, e.wd3);
        else pass_cnt++;
        set_reqs('0);
    endtask

    task automatic test_single();
        req_t    tbl[2];
        wb_exp_t e;
        logic    ga, gb;
        tbl[0] = '{ra: 1'b1, aa: AW'(5), da: 32'hDEAD_BEEF, rb: 1'b0, ab: '0, db: '0};
        tbl[1] = '0;
        for (int i = 0; i < 2; i++) begin
            set_reqs(tbl[i]);
            #1;
            model_step(ga, gb);
            total_cnt++; if (wb.gnt_a !== ga || wb.gnt_b !== gb)
                $display("FAIL single_gnt[%0d]: got a=%0b b=%0b want a=%0b b=%0b", i, wb.gnt_a, wb.gnt_b, ga, gb);
            else pass_cnt++;
            $display("txn single[%0d] gnt_a=%0b gnt_b=%0b", i, wb.gnt_a, wb.gnt_b);
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++; if (rf_we !== e.we || rf_a3 !== e.a3 || rf_wd3 !== e.wd3)
                $display("FAIL single_write[%0d]: got we=%0b a3=%0d wd3=%h want we=%0b a3=%0d wd3=%h",
                         i, rf_we, rf_a3, rf_wd3, e.we, e.a3, e.wd3);
            else pass_cnt++;
        end
    endtask

    task automatic test_contention();
        req_t    tbl[5];
        wb_exp_t e;
        logic    ga, gb;
        tbl[0] = '{ra: 1'b1, aa: AW'(10), da: 32'hA000_0010, rb: 1'b1, ab: AW'(20), db: 32'hB000_0020};
        tbl[1] = '{ra: 1'b1, aa: AW'(11), da: 32'hA000_0011, rb: 1'b1, ab: AW'(20), db: 32'hB000_0020};
        tbl[2] = '{ra: 1'b1, aa: AW'(11), da: 32'hA000_0011, rb: 1'b1, ab: AW'(21), db: 32'hB000_0021};
        tbl[3] = '{ra: 1'b1, aa: AW'(12), da: 32'hA000_0012, rb: 1'b1, ab: AW'(21), db: 32'hB000_0021};
        tbl[4] = '0;
        for (int i = 0; i < 5; i++) begin
            set_reqs(tbl[i]);
            #1;
            model_step(ga, gb);
            total_cnt++; if (wb.gnt_a !== ga || wb.gnt_b !== gb)
                $display("FAIL contention_gnt[%0d]: got a=%0b b=%0b want a=%0b b=%0b", i, wb.gnt_a, wb.gnt_b, ga, gb);
            else pass_cnt++;
            $display("txn contention[%0d] gnt_a=%0b gnt_b=%0b", i, wb.gnt_a, wb.gnt_b);
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++; if (rf_we !== e.we || rf_a3 !== e.a3 || rf_wd3 !== e.wd3)
                $display("FAIL contention_write[%0d]: got we=%0b a3=%0d wd3=%h want we=%0b a3=%0d wd3=%h",
                         i, rf_we, rf_a3, rf_wd3, e.we, e.a3, e.wd3);
            else pass_cnt++;
        end
    endtask

    task automatic test_x0();
        req_t    r;
        wb_exp_t e;
        logic    ga, gb;
        r = '{ra: 1'b0, aa: '0, da: '0, rb: 1'b1, ab: '0, db: 32'h0000_1234};
        set_reqs(r);
        #1;
        model_step(ga, gb);
        total_cnt++; if (wb.gnt_b !== 1'b1 || gb !== 1'b1)
            $display("FAIL x0_gnt_b: got %0b model %0b want 1", wb.gnt_b, gb);
        else pass_cnt++;
        $display("txn x0 gnt_a=%0b gnt_b=%0b", wb.gnt_a, wb.gnt_b);
        @(negedge clk);
        set_reqs('0);
        e = exp_q.pop_front();
        total_cnt++; if (rf_we !== e.we || rf_a3 !== e.a3 || rf_wd3 !== e.wd3)
            $display("FAIL x0_write: got we=%0b a3=%0d wd3=%h want we=%0b a3=%0d wd3=%h",
                     rf_we, rf_a3, rf_wd3, e.we, e.a3, e.wd3);
        else pass_cnt++;
        total_cnt++; if (rf_we !== 1'b0) $display("FAIL x0_rf_we: got %0b want 0", rf_we); else pass_cnt++;
        total_cnt++; if (dut.busy_reg !== '0) $display("FAIL x0_busy: got %h want 0", dut.busy_reg); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        req_t    tbl[7];
        wb_exp_t e;
        logic    ga, gb;
        tbl[0] = '{ra: 1'b1, aa: AW'(3),  da: 32'h1111_0003, rb: 1'b0, ab: '0, db: '0};
        tbl[1] = '{ra: 1'b1, aa: AW'(4),  da: 32'h1111_0004, rb: 1'b0, ab: '0, db: '0};
        tbl[2] = '{ra: 1'b1, aa: AW'(6),  da: 32'h1111_0006, rb: 1'b0, ab: '0, db: '0};
        tbl[3] = '{ra: 1'b0, aa: '0, da: '0, rb: 1'b1, ab: AW'(8), db: 32'h2222_0008};
        tbl[4] = '{ra: 1'b1, aa: AW'(13), da: 32'h1111_0013, rb: 1'b1, ab: AW'(14), db: 32'h2222_0014};
        tbl[5] = '{ra: 1'b0, aa: '0, da: '0, rb: 1'b1, ab: AW'(14), db: 32'h2222_0014};
        tbl[6] = '0;
        for (int i = 0; i < 7; i++) begin
            set_reqs(tbl[i]);
            #1;
            model_step(ga, gb);
            total_cnt++; if (wb.gnt_a !== ga || wb.gnt_b !== gb)
                $display("FAIL b2b_gnt[%0d]: got a=%0b b=%0b want a=%0b b=%0b", i, wb.gnt_a, wb.gnt_b, ga, gb);
            else pass_cnt++;
            $display("txn b2b[%0d] gnt_a=%0b gnt_b=%0b", i, wb.gnt_a, wb.gnt_b);
            @(negedge clk);
            e = exp_q.pop_front();
            total_cnt++; if (rf_we !== e.we || rf_a3 !== e.a3 || rf_wd3 !== e.wd3)
                $display("FAIL b2b_write[%0d]: got we=%0b a3=%0d wd3=%h want we=%0b a3=%0d wd3=%h",
                         i, rf_we, rf_a3, rf_wd3, e.we, e.a3, e.wd3);
            else pass_cnt++;
        end
    endtask

    task automatic test_scoreboard();
        req_t r;
        logic exp_stall, exp_hit;
        logic [WIDTH-1:0] exp_fwd;
        set_reqs('0);
        set_issue(1'b1, AW'(7), '0, '0);
        #1;
        total_cnt++; if (iss_stall !== 1'b0) $display("FAIL sb_issue_rd7: got stall=%0b want 0", iss_stall); else pass_cnt++;
        $display("txn sb issue rd=7 stall=%0b", iss_stall);
        @(negedge clk);
        set_issue(1'b1, '0, AW'(7), AW'(3));
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++; if (iss_stall !== 1'b1) $display("FAIL sb_raw_busy[%0d]: got stall=%0b want 1", i, iss_stall); else pass_cnt++;
            @(negedge clk);
        end
        r = '{ra: 1'b1, aa: AW'(7), da: 32'hCAFE_F00D, rb: 1'b0, ab: '0, db: '0};
        set_reqs(r);
        #1;
        total_cnt++; if (wb.gnt_a !== 1'b1 || iss_stall !== 1'b1)
            $display("FAIL sb_grant_cycle: got gnt_a=%0b stall=%0b want gnt_a=1 stall=1", wb.gnt_a, iss_stall);
        else pass_cnt++;
        $display("txn sb write rd=7 gnt_a=%0b", wb.gnt_a);
        @(negedge clk);
        set_reqs('0);
        #1;
`ifdef REGFILE_FWD_EN
        exp_stall = 1'b0;
        exp_hit   = 1'b1;
        exp_fwd   = 32'hCAFE_F00D;
`else
        exp_stall = 1'b1;
        exp_hit   = 1'b0;
        exp_fwd   = '0;
`endif
        total_cnt++; if (rf_we !== 1'b1 || rf_a3 !== AW'(7) || rf_wd3 !== 32'hCAFE_F00D)
            $display("FAIL sb_write7: got we=%0b a3=%0d wd3=%h want we=1 a3=7 wd3=cafef00d", rf_we, rf_a3, rf_wd3);
        else pass_cnt++;
        total_cnt++; if (iss_stall !== exp_stall) $display("FAIL sb_inflight_stall: got %0b want %0b", iss_stall, exp_stall); else pass_cnt++;
        total_cnt++; if (fwd_hit1 !== exp_hit || fwd_hit2 !== 1'b0)
            $display("FAIL sb_fwd_hit: got hit1=%0b hit2=%0b want hit1=%0b hit2=0", fwd_hit1, fwd_hit2, exp_hit);
        else pass_cnt++;
        total_cnt++; if (fwd_data !== exp_fwd) $display("FAIL sb_fwd_data: got %h want %h", fwd_data, exp_fwd); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (iss_stall !== 1'b0 || fwd_hit1 !== 1'b0)
            $display("FAIL sb_released: got stall=%0b hit1=%0b want stall=0 hit1=0", iss_stall, fwd_hit1);
        else pass_cnt++;
        @(negedge clk);
        set_issue(1'b0, '0, '0, '0);
    endtask

    task automatic test_set_clear();
        req_t r;
        r = '{ra: 1'b1, aa: AW'(9), da: 32'h0000_0099, rb: 1'b0, ab: '0, db: '0};
        set_reqs(r);
        set_issue(1'b1, AW'(9), '0, '0);
        #1;
        total_cnt++; if (wb.gnt_a !== 1'b1 || iss_stall !== 1'b0)
            $display("FAIL sc_same_edge: got gnt_a=%0b stall=%0b want gnt_a=1 stall=0", wb.gnt_a, iss_stall);
        else pass_cnt++;
        $display("txn sc write+issue rd=9 gnt_a=%0b", wb.gnt_a);
        @(negedge clk);
        set_reqs('0);
        set_issue(1'b1, AW'(9), '0, '0);
        #1;
        total_cnt++; if (dut.busy_reg[9] !== 1'b1) $display("FAIL sc_set_wins: got busy9=%0b want 1", dut.busy_reg[9]); else pass_cnt++;
        total_cnt++; if (iss_stall !== 1'b1) $display("FAIL sc_waw_stall: got %0b want 1", iss_stall); else pass_cnt++;
        @(negedge clk);
        r.da = 32'h0000_0999;
        set_reqs(r);
        set_issue(1'b0, '0, '0, '0);
        #1;
        total_cnt++; if (wb.gnt_a !== 1'b1) $display("FAIL sc_clear_gnt: got %0b want 1", wb.gnt_a); else pass_cnt++;
        $display("txn sc write rd=9 gnt_a=%0b", wb.gnt_a);
        @(negedge clk);
        set_reqs('0);
        set_issue(1'b1, AW'(9), '0, '0);
        #1;
        total_cnt++; if (iss_stall !== 1'b0) $display("FAIL sc_waw_cleared: got %0b want 0", iss_stall); else pass_cnt++;
        @(negedge clk);
        set_issue(1'b0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_reqs('0);
        set_issue(1'b0, '0, '0, '0);
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_back_to_back();
        test_scoreboard();
        test_set_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
